// File: rtl/nascom_vseq_pkg.sv
// Shared constants and row-advance helper for the NASCOM vertical sequencer.
// The PROM supplies {/vblank, /ld}; all widths and bit positions live here.
package nascom_vseq_pkg;

   localparam int ROW_W             = 5;
   localparam int SCAN_W            = 4;
   localparam int DEF_SCANS_PER_ROW = 14;
   localparam int DEF_RELOAD_ROW    = 11;
   localparam int VBLANK_BIT        = 1;
   localparam int LD_BIT            = 0;

   // Next row at a row end: /ld low reloads, otherwise count up with natural 5-bit wrap
   function automatic logic [ROW_W-1:0] row_advance(
      input logic [ROW_W-1:0] row,
      input logic             ld_n,
      input logic [ROW_W-1:0] reload
   );
      logic [ROW_W-1:0] nxt;
      if (ld_n) begin
         nxt = row + 5'd1;
      end else begin
         nxt = reload;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/nascom_vseq.sv
// NASCOM vertical sequencer: scan-line and row counters stepped by hline,
// row sequencing and vertical blanking steered by the external vertical PROM.
module nascom_vseq
   import nascom_vseq_pkg::*;
#(
   parameter int SCANS_PER_ROW = DEF_SCANS_PER_ROW,
   parameter int RELOAD_ROW    = DEF_RELOAD_ROW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              hline,
   output logic [ROW_W-1:0]  prom_a,
   output logic              prom_ce_n,
   input  logic [1:0]        prom_d,
   output logic              vblank_n,
   output logic [3:0]        vdu_row,
   output logic [SCAN_W-1:0] scan,
   output logic              row_end,
   output logic              frame_start
);

   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCANS_PER_ROW - 1);
   localparam logic [ROW_W-1:0]  RELOAD    = ROW_W'(RELOAD_ROW);
   localparam logic [ROW_W-1:0]  ROW_MAX   = 5'd31;

   logic [ROW_W-1:0]  row_r;
   logic [ROW_W-1:0]  row_nxt_s;
   logic [SCAN_W-1:0] scan_r;
   logic [SCAN_W-1:0] scan_nxt_s;
   logic              vblank_r;
   logic              tick_s;
   logic              last_line_s;

   assign tick_s      = en & hline;
   assign last_line_s = (scan_r == SCAN_LAST);

   // Row-end and frame wrap are flagged in the tick cycle that performs the update
   assign row_end     = tick_s & last_line_s;
   assign frame_start = tick_s & last_line_s & prom_d[LD_BIT] & (row_r == ROW_MAX);

   // The PROM is only deselected while the sequencer is held in reset
   assign prom_ce_n = ~rst_n;
   assign prom_a    = row_r;
   assign vdu_row   = row_r[3:0];
   assign scan      = scan_r;
   assign vblank_n  = vblank_r;

   // Next-state for the scan and row counters
   always_comb begin
      row_nxt_s  = row_r;
      scan_nxt_s = scan_r;
      if (tick_s) begin
         if (last_line_s) begin
            scan_nxt_s = 4'd0;
            row_nxt_s  = row_advance(row_r, prom_d[LD_BIT], RELOAD);
         end else begin
            scan_nxt_s = scan_r + 4'd1;
         end
      end else begin
         row_nxt_s  = row_r;
         scan_nxt_s = scan_r;
      end
   end

   // Counter state and blanking register; blanking follows the PROM even when en is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_r    <= 5'd0;
         scan_r   <= 4'd0;
         vblank_r <= 1'b0;
      end else begin
         row_r    <= row_nxt_s;
         scan_r   <= scan_nxt_s;
         vblank_r <= prom_d[VBLANK_BIT];
      end
   end

endmodule

// File: tb/tb_nascom_vseq.sv
// Scoreboard bench for nascom_vseq with a behavioural vertical PROM
// (row 1 has /ld low; rows 15..30 are visible).
module tb_nascom_vseq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       hline = 1'b0;
   logic [4:0] prom_a;
   logic       prom_ce_n;
   logic [1:0] prom_d;
   logic       vblank_n;
   logic [3:0] vdu_row;
   logic [3:0] scan;
   logic       row_end;
   logic       frame_start;

   int checks = 0;
   int errors = 0;
   int fs_seen = 0;

   typedef struct packed {
      logic [4:0] row;
      logic [3:0] scan;
      logic       vb;
   } exp_t;
   exp_t sb_q[$];

   logic [4:0] m_row = 5'd0;
   logic [3:0] m_scan = 4'd0;

   always #5 clk = ~clk;

   function automatic logic prom_ld_n(input logic [4:0] r);
      return (r != 5'd1);
   endfunction

   function automatic logic prom_vb_n(input logic [4:0] r);
      return (r >= 5'd15) && (r <= 5'd30);
   endfunction

   assign prom_d = prom_ce_n ? 2'b11 : {prom_vb_n(prom_a), prom_ld_n(prom_a)};

   nascom_vseq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .hline      (hline),
      .prom_a     (prom_a),
      .prom_ce_n  (prom_ce_n),
      .prom_d     (prom_d),
      .vblank_n   (vblank_n),
      .vdu_row    (vdu_row),
      .scan       (scan),
      .row_end    (row_end),
      .frame_start(frame_start)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock: drive at negedge, check tick-cycle pulses, push expected state, compare after the edge
   task automatic step(input logic h, input logic e);
      logic exp_re;
      logic exp_fs;
      logic [4:0] old_row;
      exp_t ex;
      hline = h;
      en    = e;
      #1;
      exp_re = h & e & (m_scan == 4'd13);
      exp_fs = exp_re & (m_row == 5'd31) & prom_ld_n(m_row);
      chk("row_end", row_end, exp_re);
      chk("frame_start", frame_start, exp_fs);
      if (frame_start) fs_seen++;
      old_row = m_row;
      if (h & e) begin
         if (m_scan == 4'd13) begin
            m_scan = 4'd0;
            m_row  = prom_ld_n(m_row) ? m_row + 5'd1 : 5'd11;
         end else begin
            m_scan = m_scan + 4'd1;
         end
      end
      sb_q.push_back('{row: m_row, scan: m_scan, vb: prom_vb_n(old_row)});
      @(posedge clk);
      @(negedge clk);
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         ex = sb_q.pop_front();
         chk("prom_a", prom_a, ex.row);
         chk("scan", scan, ex.scan);
         chk("vdu_row", vdu_row, ex.row[3:0]);
         chk("vblank_n", vblank_n, ex.vb);
         chk("prom_ce_n", prom_ce_n, 1'b0);
      end
   endtask

   // Asynchronous reset between clock edges; called at a negedge, releases at the next negedge
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      hline = 1'b0;
      en    = 1'b0;
      #1;
      chk("rst_ce_n", prom_ce_n, 1'b1);
      chk("rst_prom_a", prom_a, 5'd0);
      chk("rst_scan", scan, 4'd0);
      chk("rst_vblank_n", vblank_n, 1'b0);
      chk("rst_row_end", row_end, 1'b0);
      chk("rst_frame_start", frame_start, 1'b0);
      m_row  = 5'd0;
      m_scan = 4'd0;
      sb_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      @(negedge clk);
      do_reset();

      // First row: hline ticks from the release cycle onward
      for (int i = 0; i < 14; i++) step(1'b1, 1'b1);
      chk("row0_to_1", prom_a, 5'd1);

      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);

      // Row 1 has /ld low: reload to 11
      for (int i = 0; i < 14; i++) step(1'b1, 1'b1);
      chk("reload_11", prom_a, 5'd11);
      step(1'b0, 1'b1);
      chk("reload_vb", vblank_n, 1'b0);

      for (int i = 0; i < 56; i++) step(1'b1, 1'b1);
      chk("row15_vdu", vdu_row, 4'd15);
      step(1'b0, 1'b1);
      chk("row15_vb", vblank_n, 1'b1);
      for (int i = 0; i < 14; i++) step(1'b1, 1'b1);
      chk("row16_vdu", vdu_row, 4'd0);

      // Freeze mid-row at scan 5 with hline still pulsing
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
      for (int i = 0; i < 50; i++) step(1'(i % 2), 1'b0);
      chk("frz_scan", scan, 4'd5);
      chk("frz_row", prom_a, 5'd16);
      step(1'b1, 1'b1);
      chk("resume_scan", scan, 4'd6);

      for (int i = 0; i < 150; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));

      // Whole frame from reset: ticks up to and including the 31->0 wrap
      do_reset();
      fs_seen = 0;
      n = 0;
      while (fs_seen == 0 && n < 400) begin
         step(1'b1, 1'b1);
         n++;
      end
      chk("frame_len", n, 322);
      chk("frame_wrap_row", prom_a, 5'd0);
      step(1'b0, 1'b1);
      chk("frame_pulses", fs_seen, 1);

      // Reset abandoned mid-frame at row 20 scan 7
      n = 0;
      while (!(m_row == 5'd20 && m_scan == 4'd7) && n < 600) begin
         step(1'b1, 1'b1);
         n++;
      end
      chk("mid_row", prom_a, 5'd20);
      chk("mid_scan", scan, 4'd7);
      do_reset();
      for (int i = 0; i < 14; i++) step(1'b1, 1'b1);
      chk("post_rst_row", prom_a, 5'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
